bcd_scan_display: RTL and testbench

//  Downstream consumer of the decade-counter (IC90) chain. Takes NDIG packed BCD digits from the

---
 rtl/bcd_scan_display.sv | 111 +++++++++++
 tb/tb_bcd_scan_display.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - multiplexed 7-segment scanner for a packed BCD bus
// One digit lit per slot, with ghost blanking, leading-zero blanking and a per-frame snapshot.
module bcd_scan_display #(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                    ck,
    input  logic                    r0_n,
    input  logic                    en,
    input  logic [4*NDIG-1:0]       bcd,
    input  logic [NDIG-1:0]         dp,
    input  logic                    lzb,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic [NDIG-1:0]         an_n,
    output logic [$clog2(NDIG)-1:0] slot
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(NDIG);

    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_slot;
    logic [4*NDIG-1:0] r_snap;
    logic [NDIG-1:0]   r_snap_dp;
    logic [6:0]        r_seg;
    logic              r_seg_dp;
    logic [NDIG-1:0]   r_an_n;

    logic [4*NDIG-1:0] w_hi;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg_code;
    logic              w_guard;
    logic              w_blank;
    logic              w_dp_bit;
    logic [NDIG-1:0]   w_an;
    logic              w_cnt_last;
    logic              w_slot_last;
    logic              w_frame_start;

    always_comb begin
        // Shifting the current digit down to bit 0 also exposes everything above it:
        // if the shifted bus is zero, this digit and all more significant ones are zero.
        w_hi          = r_snap >> {r_slot, 2'b00};
        w_digit       = w_hi[3:0];
        w_guard       = (r_cnt < CW'(BLANK_CYC));
        w_blank       = lzb && (r_slot != '0) && (w_hi == '0);
        w_dp_bit      = r_snap_dp[r_slot];
        w_an          = ~(NDIG'(1) << r_slot);
        w_cnt_last    = (r_cnt == CW'(SCAN_DIV - 1));
        w_slot_last   = (r_slot == SW'(NDIG - 1));
        w_frame_start = (r_slot == '0) && (r_cnt == '0);
        case (w_digit)
            4'd0:    w_seg_code = 7'h3F;
            4'd1:    w_seg_code = 7'h06;
            4'd2:    w_seg_code = 7'h5B;
            4'd3:    w_seg_code = 7'h4F;
            4'd4:    w_seg_code = 7'h66;
            4'd5:    w_seg_code = 7'h6D;
            4'd6:    w_seg_code = 7'h7D;
            4'd7:    w_seg_code = 7'h07;
            4'd8:    w_seg_code = 7'h7F;
            4'd9:    w_seg_code = 7'h6F;
            default: w_seg_code = 7'h40;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!r0_n) begin
            r_cnt     <= '0;
            r_slot    <= '0;
            r_snap    <= '0;
            r_snap_dp <= '0;
            r_seg     <= '0;
            r_seg_dp  <= 1'b0;
            r_an_n    <= '1;
        end else if (!en) begin
            r_seg     <= '0;
            r_seg_dp  <= 1'b0;
            r_an_n    <= '1;
        end else begin
            if (w_guard || w_blank) begin
                r_seg    <= '0;
                r_seg_dp <= 1'b0;
                r_an_n   <= '1;
            end else begin
                r_seg    <= w_seg_code;
                r_seg_dp <= w_dp_bit;
                r_an_n   <= w_an;
            end
            if (w_cnt_last) begin
                r_cnt  <= '0;
                r_slot <= w_slot_last ? '0 : r_slot + 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
            // Slot 0 count 0 is always dark, so the new snapshot is never displayed the same edge.
            if (w_frame_start) begin
                r_snap    <= bcd;
                r_snap_dp <= dp;
            end
        end
    end

    assign seg    = r_seg;
    assign seg_dp = r_seg_dp;
    assign an_n   = r_an_n;
    assign slot   = r_slot;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - scoreboard bench for bcd_scan_display
// A reference model queues expected outputs per edge; directed constant checks pin key frames.
module tb_bcd_scan_display;

    localparam int NDIG = 4, SCAN_DIV = 8, BLANK_CYC = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [1:0] slot;
    } exp_t;

    logic        ck = 1'b0;
    logic        r0_n = 1'b0;
    logic        en = 1'b1;
    logic [15:0] bcd = 16'h0000;
    logic [3:0]  dp = 4'b0000;
    logic        lzb = 1'b0;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an_n;
    logic [1:0]  slot;

    int          n_pass = 0;
    int          n_total = 0;
    exp_t        q[$];

    int          m_cnt = 0;
    int          m_slot = 0;
    logic [15:0] m_snap = 16'h0;
    logic [3:0]  m_snap_dp = 4'h0;

    bcd_scan_display #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .ck(ck), .r0_n(r0_n), .en(en), .bcd(bcd), .dp(dp), .lzb(lzb),
        .seg(seg), .seg_dp(seg_dp), .an_n(an_n), .slot(slot)
    );

    always #5 ck = ~ck;

    function automatic logic [6:0] seg_tab(input logic [3:0] d);
        logic [6:0] tab [0:9];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 4'd9) return 7'h40;
        return tab[d];
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic tick();
        exp_t e;
        exp_t g;
        logic [3:0] d;
        logic upper_zero;
        e = '{seg: 7'h00, dp: 1'b0, an: 4'hF, slot: 2'd0};
        if (!r0_n) begin
            m_cnt = 0; m_slot = 0; m_snap = '0; m_snap_dp = '0;
        end else if (!en) begin
            e.slot = 2'(m_slot);
        end else begin
            d = m_snap[m_slot*4 +: 4];
            upper_zero = 1'b1;
            for (int j = m_slot; j < NDIG; j++)
                if (m_snap[j*4 +: 4] != 4'd0) upper_zero = 1'b0;
            if (!(m_cnt < BLANK_CYC) && !(lzb && m_slot > 0 && upper_zero)) begin
                e.seg = seg_tab(d);
                e.dp  = m_snap_dp[m_slot];
                e.an  = 4'hF & ~(4'b0001 << m_slot);
            end
            if (m_cnt == 0 && m_slot == 0) begin
                m_snap = bcd; m_snap_dp = dp;
            end
            if (m_cnt == SCAN_DIV - 1) begin
                m_cnt = 0;
                m_slot = (m_slot + 1) % NDIG;
            end else begin
                m_cnt++;
            end
            e.slot = 2'(m_slot);
        end
        q.push_back(e);
        @(posedge ck);
        #1;
        g = q.pop_front();
        cmp("sb_seg", {1'b0, seg}, {1'b0, g.seg});
        cmp("sb_dp", {7'b0, seg_dp}, {7'b0, g.dp});
        cmp("sb_an", {4'b0, an_n}, {4'b0, g.an});
        cmp("sb_slot", {6'b0, slot}, {6'b0, g.slot});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_out(input string tag, input logic [6:0] s, input logic p,
                              input logic [3:0] a, input logic [1:0] sl);
        cmp({tag, "_seg"}, {1'b0, seg}, {1'b0, s});
        cmp({tag, "_dp"}, {7'b0, seg_dp}, {7'b0, p});
        cmp({tag, "_an"}, {4'b0, an_n}, {4'b0, a});
        cmp({tag, "_slot"}, {6'b0, slot}, {6'b0, sl});
    endtask

    initial begin
        // reset held for 3 edges with en=1
        r0_n = 1'b0; en = 1'b1;
        run(3);
        expect_out("reset", 7'h00, 1'b0, 4'b1111, 2'd0);

        // plain scan of 1234; tick k samples pre-edge index k-1
        r0_n = 1'b1; bcd = 16'h1234; lzb = 1'b0; dp = 4'b0000;
        run(2);
        expect_out("t2_dark", 7'h00, 1'b0, 4'b1111, 2'd0);
        run(1);
        expect_out("t2_s0", 7'h66, 1'b0, 4'b1110, 2'd0);
        run(8);
        expect_out("t2_s1", 7'h4F, 1'b0, 4'b1101, 2'd1);
        run(21);
        run(32);

        // leading-zero blanking
        bcd = 16'h0070; lzb = 1'b1;
        run(11);
        expect_out("t3_s1", 7'h07, 1'b0, 4'b1101, 2'd1);
        run(16);
        expect_out("t3_s3", 7'h00, 1'b0, 4'b1111, 2'd3);
        run(5);
        bcd = 16'h0000;
        run(3);
        expect_out("t3_zero_s0", 7'h3F, 1'b0, 4'b1110, 2'd0);
        run(8);
        expect_out("t3_zero_s1", 7'h00, 1'b0, 4'b1111, 2'd1);
        run(21);

        // bus change mid-frame must not tear
        bcd = 16'h1234; lzb = 1'b0;
        run(32);
        run(20);
        bcd = 16'h5678;
        run(7);
        expect_out("t4_old_s3", 7'h06, 1'b0, 4'b0111, 2'd3);
        run(5);
        run(3);
        expect_out("t4_new_s0", 7'h7F, 1'b0, 4'b1110, 2'd0);
        run(29);

        // invalid code plus decimal point
        bcd = 16'h00A0; dp = 4'b0010; lzb = 1'b1;
        run(3);
        run(8);
        expect_out("t5_s1", 7'h40, 1'b1, 4'b1101, 2'd1);
        run(21);
        run(3);
        expect_out("t5_s0", 7'h3F, 1'b0, 4'b1110, 2'd0);
        run(29);

        // enable pause mid-slot, then reset mid-slot3
        bcd = 16'h4321; dp = 4'b0000; lzb = 1'b0;
        run(12);
        en = 1'b0;
        run(1);
        expect_out("t6_off", 7'h00, 1'b0, 4'b1111, 2'd1);
        run(2);
        en = 1'b1;
        run(1);
        expect_out("t6_resume", 7'h5B, 1'b0, 4'b1101, 2'd1);
        run(15);
        r0_n = 1'b0;
        run(1);
        expect_out("t6_reset", 7'h00, 1'b0, 4'b1111, 2'd0);
        r0_n = 1'b1; bcd = 16'h9876;
        run(3);
        expect_out("t6_fresh_s0", 7'h7D, 1'b0, 4'b1110, 2'd0);
        run(29);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
